// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin Wishbone-style arbiter in front of a single memory slave.
// Optional watchdog abort of stalled grants is built when ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int AW             = 12,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [AW-1:0] m0_adr_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_gnt;
    logic   w_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_stalled;

    assign w_stalled = ((r_state == GNT0 && m0_stb_i) || (r_state == GNT1 && m1_stb_i)) && !s_ack_i;
    assign w_timeout = w_stalled && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every new grant, on any ack, and while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == IDLE || w_next_state != r_state || s_ack_i) begin
            r_wd_cnt <= '0;
        end else if (w_stalled) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign m0_err_o = w_timeout && (r_state == GNT0);
    assign m1_err_o = w_timeout && (r_state == GNT1);
`else
    assign w_timeout = 1'b0;
    assign m0_err_o  = 1'b0;
    assign m1_err_o  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == GNT0 && r_state != GNT0) r_last_gnt <= 1'b0;
            if (w_next_state == GNT1 && r_state != GNT1) r_last_gnt <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) w_next_state = r_last_gnt ? GNT0 : GNT1;
                else if (m0_cyc_i)        w_next_state = GNT0;
                else if (m1_cyc_i)        w_next_state = GNT1;
            end
            GNT0: begin
                if (w_timeout)     w_next_state = IDLE;
                else if (!m0_cyc_i) w_next_state = m1_cyc_i ? GNT1 : IDLE;
            end
            GNT1: begin
                if (w_timeout)     w_next_state = IDLE;
                else if (!m1_cyc_i) w_next_state = m0_cyc_i ? GNT0 : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Bus mux: only the granted master reaches the slave and sees an ack.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        gnt_o    = 2'b00;
        busy_o   = 1'b0;
        case (r_state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i && !w_timeout;
                s_stb_o  = m0_stb_i && !w_timeout;
                s_adr_o  = m0_adr_i;
                m0_ack_o = s_ack_i && m0_stb_i;
                gnt_o    = 2'b01;
                busy_o   = 1'b1;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i && !w_timeout;
                s_stb_o  = m1_stb_i && !w_timeout;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i && m1_stb_i;
                gnt_o    = 2'b10;
                busy_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, single fetch, round-robin ties, write path,
// locked back-to-back transfers, reset mid-transfer, and grant hold / watchdog abort.
module tb_mem_bus_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
    logic [AW-1:0] m0_adr_i = '0;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
    logic [AW-1:0] m1_adr_i = '0;
    logic [DW-1:0] m1_dat_i = '0;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i = '0;
    logic          s_ack_i = 1'b0;
    logic [1:0]    gnt_o;
    logic          busy_o;

    int n_total = 0;
    int n_pass  = 0;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_adr_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; s_dat_i = '0; s_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        n_total++; if (gnt_o !== 2'b00) $display("FAIL rst_gnt: got %b want 00", gnt_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
        n_total++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) $display("FAIL rst_slave_ctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); else n_pass++;
        n_total++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) $display("FAIL rst_acks: got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); else n_pass++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_fetch();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 12'h010;
        m1_we_i = 1'b1; m1_dat_i = 16'hAAAA;
        #1;
        n_total++; if (gnt_o !== 2'b00) $display("FAIL fetch_latency_gnt: got %b want 00", gnt_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b0) $display("FAIL fetch_latency_cyc: got %b want 0", s_cyc_o); else n_pass++;
        tick();
        n_total++; if (gnt_o !== 2'b01) $display("FAIL fetch_gnt: got %b want 01", gnt_o); else n_pass++;
        n_total++; if ({s_cyc_o, s_stb_o, busy_o} !== 3'b111) $display("FAIL fetch_slave_ctl: got %b want 111", {s_cyc_o, s_stb_o, busy_o}); else n_pass++;
        n_total++; if (s_adr_o !== 12'h010) $display("FAIL fetch_adr: got %h want 010", s_adr_o); else n_pass++;
        n_total++; if ({s_we_o, s_dat_o} !== 17'd0) $display("FAIL fetch_we_dat: got %b/%h want 0/0000", s_we_o, s_dat_o); else n_pass++;
        n_total++; if (m0_ack_o !== 1'b0) $display("FAIL fetch_early_ack: got %b want 0", m0_ack_o); else n_pass++;
        tick();
        s_ack_i = 1'b1; s_dat_i = 16'hBEEF;
        #1;
        n_total++; if (m0_ack_o !== 1'b1) $display("FAIL fetch_ack: got %b want 1", m0_ack_o); else n_pass++;
        n_total++; if (m0_dat_o !== 16'hBEEF) $display("FAIL fetch_dat: got %h want beef", m0_dat_o); else n_pass++;
        n_total++; if (m1_ack_o !== 1'b0) $display("FAIL fetch_m1_ack: got %b want 0", m1_ack_o); else n_pass++;
        tick();
        clear_inputs();
        tick();
        n_total++; if ({gnt_o, busy_o} !== 3'b000) $display("FAIL fetch_release: got %b want 000", {gnt_o, busy_o}); else n_pass++;
    endtask

    task automatic test_round_robin();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        n_total++; if (gnt_o !== 2'b01) $display("FAIL rr_first_tie: got %b want 01", gnt_o); else n_pass++;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL rr_handover: got %b want 10", gnt_o); else n_pass++;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        n_total++; if (gnt_o !== 2'b00) $display("FAIL rr_idle: got %b want 00", gnt_o); else n_pass++;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        n_total++; if (gnt_o !== 2'b01) $display("FAIL rr_second_tie: got %b want 01", gnt_o); else n_pass++;
        n_total++; if (m1_ack_o !== 1'b0) $display("FAIL rr_holdoff_ack: got %b want 0", m1_ack_o); else n_pass++;
        clear_inputs();
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL rr_third_tie: got %b want 10", gnt_o); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_write();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 12'h3FF; m1_dat_i = 16'h1234;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_total++; if ({s_we_o, s_adr_o, s_dat_o} !== {1'b1, 12'h3FF, 16'h1234}) $display("FAIL wr_bus: got %b/%h/%h want 1/3ff/1234", s_we_o, s_adr_o, s_dat_o); else n_pass++;
            n_total++; if (m1_ack_o !== 1'b0) $display("FAIL wr_early_ack: got %b want 0", m1_ack_o); else n_pass++;
            tick();
        end
        s_ack_i = 1'b1;
        #1;
        n_total++; if ({m1_ack_o, m0_ack_o} !== 2'b10) $display("FAIL wr_ack: got %b want 10", {m1_ack_o, m0_ack_o}); else n_pass++;
        tick();
        m1_stb_i = 1'b0;
        #1;
        n_total++; if (m1_ack_o !== 1'b0) $display("FAIL wr_ack_no_stb: got %b want 0", m1_ack_o); else n_pass++;
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m1_adr_i = AW'(i + 5);
            s_ack_i = 1'b1;
            #1;
            n_total++; if ({gnt_o, m1_ack_o, m0_ack_o} !== 4'b1010) $display("FAIL b2b_ack_%0d: got %b want 1010", i, {gnt_o, m1_ack_o, m0_ack_o}); else n_pass++;
            n_total++; if (s_adr_o !== AW'(i + 5)) $display("FAIL b2b_adr_%0d: got %h want %h", i, s_adr_o, AW'(i + 5)); else n_pass++;
            tick();
            s_ack_i = 1'b0;
            #1;
            n_total++; if ({gnt_o, m1_ack_o} !== 3'b100) $display("FAIL b2b_gap_%0d: got %b want 100", i, {gnt_o, m1_ack_o}); else n_pass++;
            tick();
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        n_total++; if (gnt_o !== 2'b01) $display("FAIL b2b_m0_after: got %b want 01", gnt_o); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        n_total++; if (s_cyc_o !== 1'b1) $display("FAIL rmid_granted: got %b want 1", s_cyc_o); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_ack_i = 1'b1;
        #1;
        n_total++; if ({s_cyc_o, s_stb_o, gnt_o, busy_o} !== 5'b00000) $display("FAIL rmid_dropped: got %b want 00000", {s_cyc_o, s_stb_o, gnt_o, busy_o}); else n_pass++;
        n_total++; if ({m0_ack_o, m1_ack_o} !== 2'b00) $display("FAIL rmid_late_ack: got %b want 00", {m0_ack_o, m1_ack_o}); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        test_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            if (k < 15) begin
                n_total++; if ({m0_err_o, s_cyc_o, gnt_o} !== 4'b0101) $display("FAIL to_stall_%0d: got %b want 0101", k, {m0_err_o, s_cyc_o, gnt_o}); else n_pass++;
            end else begin
                n_total++; if ({m0_err_o, m1_err_o, s_cyc_o, s_stb_o} !== 4'b1000) $display("FAIL to_abort: got %b want 1000", {m0_err_o, m1_err_o, s_cyc_o, s_stb_o}); else n_pass++;
            end
            tick();
        end
        n_total++; if ({gnt_o, m0_err_o} !== 3'b000) $display("FAIL to_idle: got %b want 000", {gnt_o, m0_err_o}); else n_pass++;
        tick();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL to_m1_next: got %b want 10", gnt_o); else n_pass++;
`else
        for (int k = 1; k <= 20; k++) begin
            n_total++; if ({m0_err_o, m1_err_o, s_cyc_o, gnt_o} !== 5'b00101) $display("FAIL hold_%0d: got %b want 00101", k, {m0_err_o, m1_err_o, s_cyc_o, gnt_o}); else n_pass++;
            tick();
        end
`endif
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_reset();
        test_round_robin();
        test_write();
        test_back_to_back();
        test_reset_mid_transfer();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master, one-slave Wishbone-style arbiter that shares the single unified memory between the control unit's instruction-fetch port (stb/cyc/inst_ack) and data port (data_stb/data_cyc/data_we/data_ack). It sits between the CPU core and the memory slave. Grants are round-robin and held for a whole bus cycle while cyc stays high. Ack is routed back only to the granted master.

Parameters:
AW, 12, address width.
DW, 16, data width.
TIMEOUT_CYCLES, 15, cycles without s_ack before forced abort (optional feature only); minimum 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_cyc_i  in  1  fetch master cycle
m0_stb_i  in  1  fetch master strobe
m0_adr_i  in  AW  fetch address
m0_dat_o  out  DW  fetch read data
m0_ack_o  out  1  fetch ack
m0_err_o  out  1  fetch error (optional feature)
m1_cyc_i  in  1  data master cycle
m1_stb_i  in  1  data master strobe
m1_we_i  in  1  data write enable
m1_adr_i  in  AW  data address
m1_dat_i  in  DW  data write data
m1_dat_o  out  DW  data read data
m1_ack_o  out  1  data ack
m1_err_o  out  1  data error (optional feature)
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
gnt_o  out  2  one-hot grant {m1,m0}
busy_o  out  1  any grant active

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. Reset forces state IDLE and last_gnt=1, so m0 wins the first tie. All outputs are 0 in IDLE.
- States: IDLE, GNT0, GNT1. The state is registered. All slave and master outputs are combinational from the state plus the granted master's inputs.
- IDLE:
  - only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
  - both -> grant the master not equal to last_gnt.
  - none -> stay in IDLE.
  - Grant latency: 1 cycle from cyc to s_cyc_o.
- GNTx:
  - s_cyc_o=mx_cyc_i, s_stb_o=mx_stb_i, s_adr_o=mx_adr_i. s_we_o=m1_we_i in GNT1, 0 in GNT0. s_dat_o=m1_dat_i in GNT1, 0 otherwise.
  - mx_ack_o=s_ack_i & mx_stb_i. The other master's ack is 0.
  - m0_dat_o and m1_dat_o both carry s_dat_i at all times. Masters qualify the data with their own ack.
  - gnt_o is one-hot for the granted master; busy_o=1.
  - last_gnt<=x on entry.
- Release: when the granted master's cyc_i is low (sampled on a clock edge):
  - other master's cyc high -> go directly to the other GNT state, no idle cycle.
  - otherwise -> IDLE.
- A master deasserting cyc in the same cycle it receives ack completes normally. s_ack_i while stb is low is ignored.
- Back-to-back transfers by one master inside one cyc never lose the grant. Starvation is bounded because cyc drops between CPU fetch and memory phases.
- The ungranted master's requests are held off (no ack) with no side effects.
- Reset mid-transfer: the next state is IDLE, so s_cyc_o/s_stb_o drop in the cycle after rst is sampled and any pending ack is discarded.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A 4-bit-or-wider watchdog counter clears on grant entry and on s_ack_i. It increments each cycle in GNTx with stb high and no ack.
  - When the count reaches TIMEOUT_CYCLES-1, mx_err_o pulses for 1 cycle, s_cyc_o/s_stb_o are forced to 0 that cycle, and the state goes to IDLE with last_gnt=x.
  - The counter clears when the state returns to IDLE.
- Without the macro: there is no counter, m0_err_o and m1_err_o are tied to 0, and a grant is held indefinitely.

Test Plan:
- After reset, m0_cyc/stb=1 with adr=0x010, slave acks on the 2nd cycle with dat=0xBEEF -> gnt_o=01 one cycle after the request; m0_ack_o=1 with m0_dat_o=0xBEEF; m1_ack_o stays 0.
- m0 and m1 request in the same cycle from IDLE right after reset -> GNT0 first. After m0 drops cyc, GNT1 follows with no IDLE cycle. On the next simultaneous request from IDLE, m0 wins again because last_gnt=1.
- m1 write: we=1, adr=0x3FF, dat=0x1234 -> s_we_o=1, s_adr_o=0x3FF, s_dat_o=0x1234 until s_ack_i; m1_ack_o pulses once.
- m1 holds cyc across 3 stb/ack transfers while m0 requests -> gnt_o stays 10 for all three; m0 is granted in the cycle after m1_cyc drops.
- rst asserted mid-transfer in GNT1 with stb high -> next cycle s_cyc_o=0, gnt_o=00, busy_o=0; a late s_ack_i produces no master ack.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15, m0 granted and slave never acks -> m0_err_o pulses exactly once after 15 stalled cycles, the state returns to IDLE, and a pending m1 request is granted next.
